// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller.
// Opcodes, FSM states and the datapath mux/ALU select codes.
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    typedef enum logic [3:0] {
        S_IF    = 4'd0,
        S_ID    = 4'd1,
        S_MADDR = 4'd2,
        S_MRD   = 4'd3,
        S_MWB   = 4'd4,
        S_MWR   = 4'd5,
        S_EXR   = 4'd6,
        S_RWB   = 4'd7,
        S_EXI   = 4'd8,
        S_IWB   = 4'd9,
        S_BR    = 4'd10,
        S_JMP   = 4'd11
    } state_t;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_FUNCT = 4'b0010;
    localparam logic [3:0] ALU_SLT   = 4'b0011;

    localparam logic [1:0] SRC_B_RT     = 2'b00;
    localparam logic [1:0] SRC_B_FOUR   = 2'b01;
    localparam logic [1:0] SRC_B_IMM    = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_ctrl.sv
// Control FSM for the shared-ALU, shared-memory multi-cycle datapath.
// One state register, one next-state block, one output decoder.
module multicycle_ctrl
    import mc_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] instr_op_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       ir_write_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       iord_o,
    output logic       reg_write_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [3:0] alu_op_o,
    output logic [1:0] pc_src_o,
    output logic [3:0] state_o,
    output logic       illegal_o,
    output logic       retire_o
);

    // Plain vector so encodings 12-15 stay representable and recoverable.
    logic [3:0] state_q;
    logic [3:0] state_d;

    assign state_o = state_q;

    // State register, restarts fetch on reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IF;
        else       state_q <= state_d;
    end

    // Next-state: opcode dispatch in ID, memory waits in IF/MRD/MWR.
    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_IF:    state_d = mem_ready_i ? S_ID : S_IF;
            S_ID: begin
                case (instr_op_i)
                    OP_RTYPE:        state_d = S_EXR;
                    OP_ADDI,
                    OP_SLTI:         state_d = S_EXI;
                    OP_LW,
                    OP_SW:           state_d = S_MADDR;
                    OP_BEQ:          state_d = S_BR;
                    OP_J:            state_d = S_JMP;
                    default:         state_d = S_IF;
                endcase
            end
            S_MADDR: begin
                if (instr_op_i == OP_LW)      state_d = S_MRD;
                else if (instr_op_i == OP_SW) state_d = S_MWR;
                else                          state_d = S_IF;
            end
            S_MRD:   state_d = mem_ready_i ? S_MWB : S_MRD;
            S_MWB:   state_d = S_IF;
            S_MWR:   state_d = mem_ready_i ? S_IF : S_MWR;
            S_EXR:   state_d = S_RWB;
            S_RWB:   state_d = S_IF;
            S_EXI:   state_d = S_IWB;
            S_IWB:   state_d = S_IF;
            S_BR:    state_d = S_IF;
            S_JMP:   state_d = S_IF;
            default: state_d = S_IF;
        endcase
    end

    // Output decode; reset masks every strobe in the same cycle.
    always_comb begin
        pc_write_o   = 1'b0;
        ir_write_o   = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        iord_o       = 1'b0;
        reg_write_o  = 1'b0;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = SRC_B_RT;
        alu_op_o     = ALU_ADD;
        pc_src_o     = PC_SRC_ALU;
        illegal_o    = 1'b0;
        retire_o     = 1'b0;
        if (!rst_i) begin
            case (state_q)
                S_IF: begin
                    mem_read_o  = 1'b1;
                    alu_src_b_o = SRC_B_FOUR;
                    ir_write_o  = mem_ready_i;
                    pc_write_o  = mem_ready_i;
                end
                S_ID: begin
                    alu_src_b_o = SRC_B_IMM_SH;
                    case (instr_op_i)
                        OP_RTYPE, OP_ADDI, OP_SLTI, OP_LW,
                        OP_SW, OP_BEQ, OP_J: illegal_o = 1'b0;
                        default:             illegal_o = 1'b1;
                    endcase
                end
                S_MADDR: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = SRC_B_IMM;
                end
                S_MRD: begin
                    mem_read_o = 1'b1;
                    iord_o     = 1'b1;
                end
                S_MWB: begin
                    reg_write_o  = 1'b1;
                    mem_to_reg_o = 1'b1;
                    retire_o     = 1'b1;
                end
                S_MWR: begin
                    mem_write_o = 1'b1;
                    iord_o      = 1'b1;
                    retire_o    = mem_ready_i;
                end
                S_EXR: begin
                    alu_src_a_o = 1'b1;
                    alu_op_o    = ALU_FUNCT;
                end
                S_RWB: begin
                    reg_write_o = 1'b1;
                    reg_dst_o   = 1'b1;
                    retire_o    = 1'b1;
                end
                S_EXI: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = SRC_B_IMM;
                    alu_op_o    = (instr_op_i == OP_SLTI) ? ALU_SLT : ALU_ADD;
                end
                S_IWB: begin
                    reg_write_o = 1'b1;
                    retire_o    = 1'b1;
                end
                S_BR: begin
                    alu_src_a_o = 1'b1;
                    alu_op_o    = ALU_SUB;
                    pc_src_o    = PC_SRC_ALUOUT;
                    pc_write_o  = zero_i;
                    retire_o    = 1'b1;
                end
                S_JMP: begin
                    pc_src_o   = PC_SRC_JUMP;
                    pc_write_o = 1'b1;
                    retire_o   = 1'b1;
                end
                default: begin
                    retire_o = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed-vector bench for multicycle_ctrl.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] instr_op;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, ir_write, mem_read, mem_write, iord;
    logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [3:0] alu_op, state;
    logic       illegal, retire;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .instr_op_i   (instr_op),
        .zero_i       (zero),
        .mem_ready_i  (mem_ready),
        .pc_write_o   (pc_write),
        .ir_write_o   (ir_write),
        .mem_read_o   (mem_read),
        .mem_write_o  (mem_write),
        .iord_o       (iord),
        .reg_write_o  (reg_write),
        .reg_dst_o    (reg_dst),
        .mem_to_reg_o (mem_to_reg),
        .alu_src_a_o  (alu_src_a),
        .alu_src_b_o  (alu_src_b),
        .alu_op_o     (alu_op),
        .pc_src_o     (pc_src),
        .state_o      (state),
        .illegal_o    (illegal),
        .retire_o     (retire)
    );

    // Single comparison point for every check in the bench.
    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle with the given inputs; returns before the next edge.
    task automatic cyc(input logic [5:0] op, input logic z,
                       input logic rdy);
        @(negedge clk);
        instr_op  = op;
        zero      = z;
        mem_ready = rdy;
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        instr_op  = 6'd0;
        zero      = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_state", {4'd0, state}, 8'd0);
        check("rst_mem_read", {7'd0, mem_read}, 8'd0);
        check("rst_pc_write", {7'd0, pc_write}, 8'd0);
        check("rst_src_b", {6'd0, alu_src_b}, 8'd0);

        // Release with memory not ready: one idle IF cycle.
        @(negedge clk);
        rst       = 1'b0;
        mem_ready = 1'b0;
        #1;
        check("if_wait_state", {4'd0, state}, 8'd0);
        check("if_wait_ir_write", {7'd0, ir_write}, 8'd0);
        check("if_wait_mem_read", {7'd0, mem_read}, 8'd1);

        // R-type add, zero-wait memory: 0,1,6,7.
        cyc(6'd0, 1'b0, 1'b1);
        check("r_c1_state", {4'd0, state}, 8'd0);
        check("r_c1_pc_write", {7'd0, pc_write}, 8'd1);
        check("r_c1_ir_write", {7'd0, ir_write}, 8'd1);
        check("r_c1_src_b", {6'd0, alu_src_b}, 8'd1);
        check("r_c1_reg_write", {7'd0, reg_write}, 8'd0);
        cyc(6'd0, 1'b0, 1'b1);
        check("r_c2_state", {4'd0, state}, 8'd1);
        check("r_c2_src_b", {6'd0, alu_src_b}, 8'd3);
        check("r_c2_pc_write", {7'd0, pc_write}, 8'd0);
        cyc(6'd0, 1'b0, 1'b1);
        check("r_c3_state", {4'd0, state}, 8'd6);
        check("r_c3_alu_op", {4'd0, alu_op}, 8'd2);
        check("r_c3_src_a", {7'd0, alu_src_a}, 8'd1);
        check("r_c3_reg_write", {7'd0, reg_write}, 8'd0);
        cyc(6'd0, 1'b0, 1'b1);
        check("r_c4_state", {4'd0, state}, 8'd7);
        check("r_c4_reg_write", {7'd0, reg_write}, 8'd1);
        check("r_c4_reg_dst", {7'd0, reg_dst}, 8'd1);
        check("r_c4_retire", {7'd0, retire}, 8'd1);

        // lw with two wait cycles in MRD: 0,1,2,3,3,3,4.
        cyc(6'd35, 1'b0, 1'b1);
        check("lw_if_state", {4'd0, state}, 8'd0);
        check("lw_if_retire", {7'd0, retire}, 8'd0);
        cyc(6'd35, 1'b0, 1'b1);
        check("lw_id_state", {4'd0, state}, 8'd1);
        cyc(6'd35, 1'b0, 1'b1);
        check("lw_maddr_state", {4'd0, state}, 8'd2);
        check("lw_maddr_src_b", {6'd0, alu_src_b}, 8'd2);
        for (int i = 0; i < 3; i++) begin
            cyc(6'd35, 1'b0, (i == 2));
            check("lw_mrd_state", {4'd0, state}, 8'd3);
            check("lw_mrd_iord", {7'd0, iord}, 8'd1);
            check("lw_mrd_mem_read", {7'd0, mem_read}, 8'd1);
            check("lw_mrd_reg_write", {7'd0, reg_write}, 8'd0);
            check("lw_mrd_mem_to_reg", {7'd0, mem_to_reg}, 8'd0);
        end
        cyc(6'd35, 1'b0, 1'b1);
        check("lw_mwb_state", {4'd0, state}, 8'd4);
        check("lw_mwb_reg_write", {7'd0, reg_write}, 8'd1);
        check("lw_mwb_mem_to_reg", {7'd0, mem_to_reg}, 8'd1);
        check("lw_mwb_reg_dst", {7'd0, reg_dst}, 8'd0);
        check("lw_mwb_retire", {7'd0, retire}, 8'd1);

        // beq taken, then not taken.
        for (int t = 0; t < 2; t++) begin
            cyc(6'd4, 1'b0, 1'b1);
            check("beq_if_state", {4'd0, state}, 8'd0);
            cyc(6'd4, 1'b0, 1'b1);
            check("beq_id_state", {4'd0, state}, 8'd1);
            cyc(6'd4, (t == 0), 1'b1);
            check("beq_br_state", {4'd0, state}, 8'd10);
            check("beq_br_pc_write", {7'd0, pc_write}, {7'd0, (t == 0)});
            check("beq_br_pc_src", {6'd0, pc_src}, 8'd1);
            check("beq_br_alu_op", {4'd0, alu_op}, 8'd1);
            check("beq_br_retire", {7'd0, retire}, 8'd1);
        end

        // slti: EXI selects slt, IWB writes rt.
        cyc(6'd10, 1'b0, 1'b1);
        cyc(6'd10, 1'b0, 1'b1);
        check("slti_id_state", {4'd0, state}, 8'd1);
        cyc(6'd10, 1'b0, 1'b1);
        check("slti_exi_state", {4'd0, state}, 8'd8);
        check("slti_exi_alu_op", {4'd0, alu_op}, 8'd3);
        check("slti_exi_src_b", {6'd0, alu_src_b}, 8'd2);
        cyc(6'd10, 1'b0, 1'b1);
        check("slti_iwb_state", {4'd0, state}, 8'd9);
        check("slti_iwb_reg_write", {7'd0, reg_write}, 8'd1);
        check("slti_iwb_reg_dst", {7'd0, reg_dst}, 8'd0);

        // Illegal opcode 3F: ID flags it once and returns to IF.
        cyc(6'h3F, 1'b0, 1'b1);
        check("ill_if_state", {4'd0, state}, 8'd0);
        cyc(6'h3F, 1'b0, 1'b1);
        check("ill_id_state", {4'd0, state}, 8'd1);
        check("ill_id_illegal", {7'd0, illegal}, 8'd1);
        check("ill_id_reg_write", {7'd0, reg_write}, 8'd0);
        check("ill_id_mem_write", {7'd0, mem_write}, 8'd0);
        cyc(6'h3F, 1'b0, 1'b0);
        check("ill_after_state", {4'd0, state}, 8'd0);
        check("ill_after_illegal", {7'd0, illegal}, 8'd0);
        check("ill_after_reg_write", {7'd0, reg_write}, 8'd0);

        // Reset raised in RWB drops the write in the same cycle.
        cyc(6'd0, 1'b0, 1'b1);
        cyc(6'd0, 1'b0, 1'b1);
        cyc(6'd0, 1'b0, 1'b1);
        cyc(6'd0, 1'b0, 1'b1);
        check("rrst_pre_state", {4'd0, state}, 8'd7);
        check("rrst_pre_reg_write", {7'd0, reg_write}, 8'd1);
        rst = 1'b1;
        #1;
        check("rrst_reg_write", {7'd0, reg_write}, 8'd0);
        check("rrst_state", {4'd0, state}, 8'd0);
        check("rrst_retire", {7'd0, retire}, 8'd0);
        @(negedge clk);
        rst       = 1'b0;
        mem_ready = 1'b0;
        #1;
        check("rrst_rel_state", {4'd0, state}, 8'd0);
        check("rrst_rel_mem_read", {7'd0, mem_read}, 8'd1);

        // sw then j back to back: retire in cycles 4 and 7.
        cyc(6'd43, 1'b0, 1'b1);
        check("sw_c1_state", {4'd0, state}, 8'd0);
        cyc(6'd43, 1'b0, 1'b1);
        check("sw_c2_state", {4'd0, state}, 8'd1);
        check("sw_c2_mem_write", {7'd0, mem_write}, 8'd0);
        cyc(6'd43, 1'b0, 1'b1);
        check("sw_c3_state", {4'd0, state}, 8'd2);
        check("sw_c3_mem_write", {7'd0, mem_write}, 8'd0);
        cyc(6'd43, 1'b0, 1'b1);
        check("sw_c4_state", {4'd0, state}, 8'd5);
        check("sw_c4_mem_write", {7'd0, mem_write}, 8'd1);
        check("sw_c4_mem_read", {7'd0, mem_read}, 8'd0);
        check("sw_c4_iord", {7'd0, iord}, 8'd1);
        check("sw_c4_retire", {7'd0, retire}, 8'd1);
        cyc(6'd2, 1'b0, 1'b1);
        check("j_c5_state", {4'd0, state}, 8'd0);
        check("j_c5_mem_write", {7'd0, mem_write}, 8'd0);
        check("j_c5_retire", {7'd0, retire}, 8'd0);
        cyc(6'd2, 1'b0, 1'b1);
        check("j_c6_state", {4'd0, state}, 8'd1);
        cyc(6'd2, 1'b0, 1'b1);
        check("j_c7_state", {4'd0, state}, 8'd11);
        check("j_c7_pc_write", {7'd0, pc_write}, 8'd1);
        check("j_c7_pc_src", {6'd0, pc_src}, 8'd2);
        check("j_c7_retire", {7'd0, retire}, 8'd1);
        check("j_c7_mem_write", {7'd0, mem_write}, 8'd0);
        cyc(6'd2, 1'b0, 1'b0);
        check("j_done_state", {4'd0, state}, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
